// File: rtl/nibble_serial_subtractor_if.sv
// Operand/result handshake bundle for the nibble-serial subtractor.
// The master drives operands and out_ready; the slave returns the difference and flags.
interface nibble_serial_subtractor_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             ovf;

   modport master (
      output in_valid, a, b, bin, out_ready,
      input  in_ready, out_valid, diff, bout, ovf
   );

   modport slave (
      input  in_valid, a, b, bin, out_ready,
      output in_ready, out_valid, diff, bout, ovf
   );
endinterface

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle a - b - bin: one 4-bit carry-skip slice of A + ~B + carry per clock, LSB first.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | one nibble of the difference computed per cycle
// DONE  | result held on the bus until out_ready
module nibble_serial_subtractor #(
   parameter int WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   nibble_serial_subtractor_if.slave  bus
);
   localparam int NIB   = WIDTH / 4;
   localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
   localparam int MSB   = WIDTH - 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, nb_q, diff_q;
   logic             carry_q;
   logic [IDX_W-1:0] idx_q;
   logic             bout_q, ovf_q;

   logic [3:0]       a_nib, nb_nib, p_nib, s_nib;
   logic [4:0]       c_rip;
   logic             carry_next;
   logic             last_nib, accept, drain;

   assign accept   = (state_q == IDLE) && bus.in_valid;
   assign drain    = (state_q == DONE) && bus.out_ready;
   assign last_nib = (idx_q == IDX_W'(NIB - 1));

   // Subtraction as A + ~B + ~bin; a nibble whose bits all propagate skips its carry straight through.
   always_comb begin
      a_nib  = a_q[4*idx_q +: 4];
      nb_nib = nb_q[4*idx_q +: 4];
      p_nib  = a_nib ^ nb_nib;
      s_nib  = 4'b0;
      c_rip  = {4'b0, carry_q};
      for (int i = 0; i < 4; i++) begin
         s_nib[i]   = p_nib[i] ^ c_rip[i];
         c_rip[i+1] = (a_nib[i] & nb_nib[i]) | (p_nib[i] & c_rip[i]);
      end
      carry_next = (&p_nib) ? carry_q : c_rip[4];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)   state_d = RUN;
         RUN:     if (last_nib) state_d = DONE;
         DONE:    if (drain)    state_d = IDLE;
         default:               state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         nb_q    <= '0;
         diff_q  <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (accept) begin
         a_q     <= bus.a;
         nb_q    <= ~bus.b;
         carry_q <= ~bus.bin;
         idx_q   <= '0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (state_q == RUN) begin
         diff_q[4*idx_q +: 4] <= s_nib;
         carry_q              <= carry_next;
         idx_q                <= idx_q + IDX_W'(1);
         if (last_nib) begin
            bout_q <= ~carry_next;
            // s_nib[3] is the final diff MSB; b's MSB is the complement of the latched ~b.
            ovf_q  <= (a_q[MSB] != ~nb_q[MSB]) && (s_nib[3] != a_q[MSB]);
         end
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.diff      = diff_q;
   assign bus.bout      = bout_q;
   assign bus.ovf       = ovf_q;
endmodule
